digital_lock_multi: RTL
=======================

DIGITAL_LOCK_MULTI -- requirements
Module: digital_lock_multi

Interface
REQ-001 Parameter DIGITS, default 4, number of digits in the unlock code (1..16).
REQ-002 Parameter KEYS, default 4, number of keys; key i enters digit value i; KW = max(1, clog2(KEYS)).
REQ-003 Parameter UNLOCK_CODE, width DIGITS*KW, default 8'h1B (sequence 0,1,2,3); first digit is UNLOCK_CODE[DIGITS*KW-1 -: KW].
REQ-004 Parameter MAX_ATTEMPTS, default 3, consecutive failures that trigger lockout.
REQ-005 Parameter LOCKOUT_CYCLES, default 1000, lockout duration in clock cycles.
REQ-006 clock  in  1  single system clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 key  in  KEYS  key levels, 1 = pressed, already synchronised.
REQ-009 relock  in  1  level; re-locks from UNLOCKED, aborts entry or programming.
REQ-010 prog  in  1  level; requests code programming from UNLOCKED (only with DIGITLOCK_PROG_EN).
REQ-011 locked  out  1  high in every state except UNLOCKED and PROG.
REQ-012 error  out  1  high only in ERROR.
REQ-013 lockout  out  1  high only in LOCKOUT.
REQ-014 state  out  3  state code: ENTRY=0, UNLOCKED=1, ERROR=2, LOCKOUT=3, PROG=4.
REQ-015 digits_entered  out  clog2(DIGITS+1)  digits accepted in current entry or programming sequence.

Function
REQ-016 A press SHALL be accepted on a cycle where key has exactly one bit set and the registered previous key value was all-zero; multi-bit or held keys SHALL be ignored.
REQ-017 All outputs SHALL be decoded from registered state, taking effect on the rising edge that samples the causing input.
REQ-018 In ENTRY each accepted press SHALL increment digits_entered and clear an internal match flag if the digit differs from the active code digit at that position.
REQ-019 On the DIGITS-th press, ENTRY SHALL go to UNLOCKED if all digits matched, else to ERROR; digits_entered SHALL return to 0.
REQ-020 UNLOCKED SHALL clear the failure counter.
REQ-021 ERROR SHALL last exactly one cycle, incrementing the failure counter; it SHALL go to LOCKOUT if the incremented count equals MAX_ATTEMPTS, else to ENTRY.
REQ-022 LOCKOUT SHALL ignore key and relock for exactly LOCKOUT_CYCLES cycles, then go to ENTRY with failure counter cleared.
REQ-023 relock high in ENTRY SHALL clear digits_entered and the match flag without counting a failure.
REQ-024 relock high in UNLOCKED SHALL go to ENTRY on the next edge; relock SHALL take priority over a simultaneous key press or prog.
REQ-025 Failure counter width SHALL be clog2(MAX_ATTEMPTS+1) and SHALL never wrap.
REQ-026 Lockout counter SHALL be sized for LOCKOUT_CYCLES and SHALL reset on every LOCKOUT entry.

Reset
REQ-027 reset low SHALL immediately force state ENTRY, locked=1, error=0, lockout=0, digits_entered=0, failure and lockout counters 0.
REQ-028 Active code register SHALL reset to UNLOCK_CODE; reset mid-entry, mid-lockout or mid-programming SHALL discard all progress.

Configuration
REQ-029 With DIGITLOCK_PROG_EN defined, prog high in UNLOCKED (relock low) SHALL enter PROG; DIGITS accepted presses fill a shadow register, then the shadow copies to the active code and state returns to UNLOCKED.
REQ-030 With DIGITLOCK_PROG_EN defined, relock in PROG SHALL return to ENTRY with the active code unchanged.
REQ-031 Without DIGITLOCK_PROG_EN, prog SHALL be ignored, PROG SHALL be unreachable and the active code SHALL be constant UNLOCK_CODE.

Verification
REQ-032 Defaults, reset release, presses 0,1,2,3 -> locked=0, state=1 on edge sampling 4th press; relock -> locked=1, state=0.
REQ-033 Presses 0,1,2,2 -> error=1 for one cycle, then state=0, locked=1.
REQ-034 Three wrong sequences -> lockout=1 for exactly 1000 cycles, presses during lockout ignored, then state=0; correct code then unlocks.
REQ-035 key=4'b0011 and held key 4'b0001 over several cycles -> no press or only one digit counted; relock after 2 digits -> digits_entered=0, no failure counted.
REQ-036 With DIGITLOCK_PROG_EN: unlock, prog, presses 3,3,1,0 -> UNLOCKED; relock; 0,1,2,3 -> error; 3,3,1,0 -> unlocks; reset -> code 0,1,2,3 again.
REQ-037 Reset asserted during 2nd digit and during lockout -> state=0, counters 0, outputs at reset values immediately.

Source files
------------

// File: rtl/digital_lock_multi.sv
// Multi-digit keypad lock with failure counting and timed lockout.
// Define DIGITLOCK_PROG_EN to allow reprogramming the unlock code from UNLOCKED.
module digital_lock_multi #(
    parameter int DIGITS         = 4,
    parameter int KEYS           = 4,
    parameter logic [DIGITS*((KEYS > 1) ? $clog2(KEYS) : 1)-1:0] UNLOCK_CODE = 8'h1B,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [KEYS-1:0]               key,
    input  logic                          relock,
    input  logic                          prog,
    output logic                          locked,
    output logic                          error,
    output logic                          lockout,
    output logic [2:0]                    state,
    output logic [$clog2(DIGITS+1)-1:0]   digits_entered
);

    localparam int KW  = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int CW  = DIGITS * KW;
    localparam int DCW = $clog2(DIGITS + 1);
    localparam int FCW = $clog2(MAX_ATTEMPTS + 1);
    localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DCW-1:0] LAST_DIGIT = DCW'(DIGITS - 1);
    localparam logic [FCW-1:0] MAX_FAIL   = FCW'(MAX_ATTEMPTS);
    localparam logic [LCW-1:0] LAST_LCNT  = LCW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_UNLOCKED = 3'd1,
        ST_ERROR    = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_PROG     = 3'd4
    } state_t;

    function automatic logic is_onehot(input logic [KEYS-1:0] v);
        return (v != {KEYS{1'b0}}) && ((v & (v - KEYS'(1))) == {KEYS{1'b0}});
    endfunction

    state_t          state_r, state_n;
    logic [KEYS-1:0] key_prev_r;
    logic [DCW-1:0]  digits_r, digits_n;
    logic            match_r, match_n;
    logic [FCW-1:0]  fail_r, fail_n, fail_inc_s;
    logic [LCW-1:0]  lcnt_r, lcnt_n;
    logic [CW-1:0]   code_s;
    logic [KW-1:0]   digit_s, code_digit_s;
    logic            press_s, digit_ok_s, prog_req_s;

`ifdef DIGITLOCK_PROG_EN
    logic [CW-1:0]   code_r, code_n, shadow_r, shadow_n;
    assign code_s     = code_r;
    assign prog_req_s = prog;
`else
    logic            unused_prog_s;
    assign code_s        = UNLOCK_CODE;
    assign prog_req_s    = 1'b0;
    assign unused_prog_s = prog;
`endif

    assign press_s      = is_onehot(key) && (key_prev_r == {KEYS{1'b0}});
    assign code_digit_s = code_s[(DIGITS - 1 - int'(digits_r)) * KW +: KW];
    assign digit_ok_s   = (digit_s == code_digit_s);
    assign fail_inc_s   = (fail_r != MAX_FAIL) ? (fail_r + FCW'(1)) : fail_r;

    // Binary value of the pressed key (only meaningful when exactly one bit is set)
    always_comb begin
        digit_s = {KW{1'b0}};
        for (int i = 0; i < KEYS; i++) begin
            digit_s = digit_s | (key[i] ? KW'(i) : {KW{1'b0}});
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state_r;
        digits_n = digits_r;
        match_n  = match_r;
        fail_n   = fail_r;
        lcnt_n   = lcnt_r;
`ifdef DIGITLOCK_PROG_EN
        code_n   = code_r;
        shadow_n = shadow_r;
`endif
        case (state_r)
            ST_ENTRY: begin
                if (relock) begin
                    digits_n = {DCW{1'b0}};
                    match_n  = 1'b1;
                end else if (press_s) begin
                    if (digits_r == LAST_DIGIT) begin
                        state_n  = (match_r && digit_ok_s) ? ST_UNLOCKED : ST_ERROR;
                        digits_n = {DCW{1'b0}};
                        match_n  = 1'b1;
                    end else begin
                        digits_n = digits_r + DCW'(1);
                        match_n  = match_r & digit_ok_s;
                    end
                end else begin
                    state_n = ST_ENTRY;
                end
            end
            ST_UNLOCKED: begin
                fail_n = {FCW{1'b0}};
                if (relock) begin
                    state_n = ST_ENTRY;
                end else if (prog_req_s) begin
                    state_n  = ST_PROG;
                    digits_n = {DCW{1'b0}};
                end else begin
                    state_n = ST_UNLOCKED;
                end
            end
            ST_ERROR: begin
                fail_n = fail_inc_s;
                if (fail_inc_s == MAX_FAIL) begin
                    state_n = ST_LOCKOUT;
                    lcnt_n  = {LCW{1'b0}};
                end else begin
                    state_n = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (lcnt_r == LAST_LCNT) begin
                    state_n = ST_ENTRY;
                    fail_n  = {FCW{1'b0}};
                    lcnt_n  = {LCW{1'b0}};
                end else begin
                    lcnt_n = lcnt_r + LCW'(1);
                end
            end
            ST_PROG: begin
`ifdef DIGITLOCK_PROG_EN
                if (relock) begin
                    state_n  = ST_ENTRY;
                    digits_n = {DCW{1'b0}};
                end else if (press_s) begin
                    shadow_n[(DIGITS - 1 - int'(digits_r)) * KW +: KW] = digit_s;
                    if (digits_r == LAST_DIGIT) begin
                        code_n   = shadow_n;
                        state_n  = ST_UNLOCKED;
                        digits_n = {DCW{1'b0}};
                    end else begin
                        digits_n = digits_r + DCW'(1);
                    end
                end else begin
                    state_n = ST_PROG;
                end
`else
                state_n  = ST_ENTRY;
                digits_n = {DCW{1'b0}};
`endif
            end
            default: begin
                state_n  = ST_ENTRY;
                digits_n = {DCW{1'b0}};
                match_n  = 1'b1;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_ENTRY;
            key_prev_r <= {KEYS{1'b0}};
            digits_r   <= {DCW{1'b0}};
            match_r    <= 1'b1;
            fail_r     <= {FCW{1'b0}};
            lcnt_r     <= {LCW{1'b0}};
`ifdef DIGITLOCK_PROG_EN
            code_r     <= UNLOCK_CODE;
            shadow_r   <= UNLOCK_CODE;
`endif
        end else begin
            state_r    <= state_n;
            key_prev_r <= key;
            digits_r   <= digits_n;
            match_r    <= match_n;
            fail_r     <= fail_n;
            lcnt_r     <= lcnt_n;
`ifdef DIGITLOCK_PROG_EN
            code_r     <= code_n;
            shadow_r   <= shadow_n;
`endif
        end
    end

    assign state          = state_r;
    assign locked         = (state_r != ST_UNLOCKED) && (state_r != ST_PROG);
    assign error          = (state_r == ST_ERROR);
    assign lockout        = (state_r == ST_LOCKOUT);
    assign digits_entered = digits_r;

endmodule
